// File: rtl/rc4_pkg.sv
// Shared types and helpers for the RC4 brute-force core scheduler.
package rc4_pkg;

  localparam int DEFAULT_KEY_W = 22;
  localparam int MAX_CORES     = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RESET_CORES,
    ST_RUN,
    ST_FOUND,
    ST_EXHAUSTED
  } sched_state_t;

  function automatic logic [4:0] popcount(input logic [MAX_CORES-1:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < MAX_CORES; i++) begin
      n = n + 5'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/rc4_core_scheduler_if.sv
// Bus between the scheduler (master) and its bank of RC4 cracking cores (slave).
interface rc4_core_scheduler_if
  import rc4_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int KEY_W     = DEFAULT_KEY_W
);

  logic                       core_rst;
  logic [NUM_CORES*KEY_W-1:0] core_base;
  logic [7:0]                 core_stride;
  logic                       stop_all;
  logic [NUM_CORES-1:0]       core_solved;
  logic [NUM_CORES*KEY_W-1:0] core_key;
  logic [NUM_CORES-1:0]       core_key_done;

  modport master (
    output core_rst, core_base, core_stride, stop_all,
    input  core_solved, core_key, core_key_done
  );

  modport slave (
    input  core_rst, core_base, core_stride, stop_all,
    output core_solved, core_key, core_key_done
  );

endinterface

// File: rtl/rc4_solve_arbiter.sv
// Fixed-priority solve arbiter: the lowest-index solved core wins and its key is muxed out.
module rc4_solve_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int KEY_W     = 22,
  parameter int FC_W      = 2
) (
  input  logic [NUM_CORES-1:0]       solved,
  input  logic [NUM_CORES*KEY_W-1:0] keys,
  output logic                       any_solved,
  output logic [FC_W-1:0]            winner,
  output logic [KEY_W-1:0]           winner_key
);

  assign any_solved = |solved;

  // Scan from the top down so the last hit written is the lowest index.
  always_comb begin
    winner = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (solved[i]) winner = FC_W'(i);
    end
  end

  always_comb begin
    winner_key = keys[int'(winner)*KEY_W +: KEY_W];
  end

endmodule

// File: rtl/rc4_core_scheduler.sv
// Sequencer for a bank of RC4 brute-force cores: reset/release, solve arbitration, exhaustion.
module rc4_core_scheduler
  import rc4_pkg::*;
#(
  parameter int NUM_CORES  = 4,
  parameter int KEY_W      = DEFAULT_KEY_W,
  parameter int RST_CYCLES = 2,
  localparam int FC_W      = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  rc4_core_scheduler_if.master cores,
  output logic                busy,
  output logic                done,
  output logic                found,
  output logic [KEY_W-1:0]    found_key,
  output logic [FC_W-1:0]     found_core,
  output logic [KEY_W:0]      keys_tried
);

  localparam int CNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  // Two guard bits so the running sum cannot wrap before the compare.
  localparam int SUM_W = KEY_W + 2;
  localparam logic [SUM_W-1:0] KEYSPACE = SUM_W'(1) << KEY_W;

  sched_state_t     state, state_nx;
  logic [CNT_W-1:0] rst_cnt, rst_cnt_nx;

  logic             core_rst_nx, stop_all_nx, busy_nx, done_nx, found_nx;
  logic [KEY_W-1:0] found_key_nx;
  logic [FC_W-1:0]  found_core_nx;
  logic [KEY_W:0]   keys_tried_nx;

  logic             any_solved;
  logic [FC_W-1:0]  winner;
  logic [KEY_W-1:0] winner_key;
  logic [4:0]       done_cnt;
  logic [SUM_W-1:0] tried_sum;

  for (genvar i = 0; i < NUM_CORES; i++) begin : g_base
    assign cores.core_base[i*KEY_W +: KEY_W] = KEY_W'(i);
  end
  assign cores.core_stride = 8'(NUM_CORES);

  rc4_solve_arbiter #(
    .NUM_CORES (NUM_CORES),
    .KEY_W     (KEY_W),
    .FC_W      (FC_W)
  ) u_arb (
    .solved     (cores.core_solved),
    .keys       (cores.core_key),
    .any_solved (any_solved),
    .winner     (winner),
    .winner_key (winner_key)
  );

  assign done_cnt  = popcount(MAX_CORES'(cores.core_key_done));
  assign tried_sum = SUM_W'(keys_tried) + SUM_W'(done_cnt);

  always_comb begin
    state_nx      = state;
    rst_cnt_nx    = rst_cnt;
    found_key_nx  = found_key;
    found_core_nx = found_core;
    keys_tried_nx = keys_tried;

    if (abort && (state != ST_IDLE)) begin
      state_nx      = ST_IDLE;
      found_key_nx  = '0;
      found_core_nx = '0;
      keys_tried_nx = '0;
    end else if (start && ((state == ST_IDLE) || (state == ST_FOUND) ||
                           (state == ST_EXHAUSTED))) begin
      state_nx      = ST_RESET_CORES;
      rst_cnt_nx    = CNT_W'(RST_CYCLES - 1);
      found_key_nx  = '0;
      found_core_nx = '0;
      keys_tried_nx = '0;
    end else begin
      case (state)
        ST_RESET_CORES: begin
          if (rst_cnt == '0) state_nx = ST_RUN;
          else               rst_cnt_nx = rst_cnt - 1'b1;
        end
        ST_RUN: begin
          keys_tried_nx = tried_sum[KEY_W:0];
          if (any_solved) begin
            state_nx      = ST_FOUND;
            found_core_nx = winner;
            found_key_nx  = winner_key;
          end else if (tried_sum >= KEYSPACE) begin
            state_nx = ST_EXHAUSTED;
          end
        end
        default: ;
      endcase
    end

    // Status outputs are a pure function of the state being entered.
    core_rst_nx = (state_nx == ST_IDLE) || (state_nx == ST_RESET_CORES);
    busy_nx     = (state_nx == ST_RESET_CORES) || (state_nx == ST_RUN);
    stop_all_nx = (state_nx == ST_FOUND) || (state_nx == ST_EXHAUSTED);
    done_nx     = stop_all_nx;
    found_nx    = (state_nx == ST_FOUND);
  end

  // Registered state and outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      rst_cnt        <= '0;
      cores.core_rst <= 1'b1;
      cores.stop_all <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      found          <= 1'b0;
      found_key      <= '0;
      found_core     <= '0;
      keys_tried     <= '0;
    end else begin
      state          <= state_nx;
      rst_cnt        <= rst_cnt_nx;
      cores.core_rst <= core_rst_nx;
      cores.stop_all <= stop_all_nx;
      busy           <= busy_nx;
      done           <= done_nx;
      found          <= found_nx;
      found_key      <= found_key_nx;
      found_core     <= found_core_nx;
      keys_tried     <= keys_tried_nx;
    end
  end

endmodule
